// File: rtl/conv_block_scheduler.sv
// Job sequencer for the column-block address FSM: LOAD -> PROC -> READ per block, N blocks per job.
// All outputs registered (one cycle after the deciding edge); host/downstream stalls via o_inRdy / i_outRdy.
module conv_block_scheduler #(
    parameter int NB_IMAGE   = 10,
    parameter int NB_BLOCKS  = 8,
    parameter int NB_TIMEOUT = 12,
    parameter int TIMEOUT    = 4000
) (
    input  logic                 i_CLK,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_BLOCKS-1:0] i_nBlocks,
    input  logic [NB_IMAGE-1:0]  i_imgLength,
    input  logic                 i_inVld,
    output logic                 o_inRdy,
    input  logic                 i_outRdy,
    output logic                 o_outVld,
    output logic                 o_load,
    output logic                 o_SoP,
    output logic                 o_valid,
    output logic [NB_IMAGE-1:0]  o_imgLength,
    input  logic                 i_EoP,
    input  logic                 i_changeBlock,
    output logic [NB_BLOCKS-1:0] o_blockIdx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_LWAIT, S_PROC, S_PDRAIN, S_READ, S_RWAIT, S_NEXT, S_DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NB_IMAGE-1:0]   r_len, w_len_nxt;
    logic [NB_BLOCKS-1:0]  r_nblk, w_nblk_nxt;
    logic [NB_BLOCKS-1:0]  r_blk, w_blk_nxt;
    logic [NB_IMAGE:0]     r_cnt, w_cnt_nxt;
    logic [NB_TIMEOUT-1:0] r_wd, w_wd_nxt;
    logic r_load, r_sop, r_valid, r_inrdy, r_outvld, r_busy, r_done, r_error;
    logic w_busy_nxt, w_error_nxt, w_done_nxt;
    logic w_accept, w_wait, w_last, w_can;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_nblk_nxt  = r_nblk;
        w_blk_nxt   = r_blk;
        w_cnt_nxt   = r_cnt;
        w_wd_nxt    = '0;
        w_busy_nxt  = r_busy;
        w_error_nxt = r_error;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_wait      = 1'b0;
        w_last      = (r_cnt == {1'b0, r_len});
        w_can       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_len_nxt   = i_imgLength;
                    w_nblk_nxt  = i_nBlocks;
                    w_blk_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_error_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (i_nBlocks == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD, S_READ: begin
                // A word is only taken while o_valid is low, so pulses are edge-separated.
                if (r_state == S_LOAD)
                    w_can = i_inVld && r_inrdy;
                else
                    w_can = i_outRdy && !r_valid && (r_cnt <= {1'b0, r_len});
                if (w_can) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_state == S_LOAD) ? S_LWAIT : S_RWAIT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_LWAIT: begin
                w_wait = 1'b1;
                if (i_changeBlock) w_state_nxt = S_PROC;
            end
            S_PROC: begin
                w_wait = 1'b1;
                if (i_EoP) w_state_nxt = S_PDRAIN;
            end
            S_PDRAIN: w_state_nxt = S_READ;
            S_RWAIT: begin
                w_wait = 1'b1;
                if (i_changeBlock) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                // Index stays on the last block when the job completes.
                if (({1'b0, r_blk} + 1'b1) == {1'b0, r_nblk}) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_blk_nxt   = r_blk + 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_wait && (w_state_nxt == r_state)) begin
            if (r_wd == NB_TIMEOUT'(TIMEOUT - 1)) begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end else begin
                w_wd_nxt = r_wd + 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_nblk   <= '0;
            r_blk    <= '0;
            r_cnt    <= '0;
            r_wd     <= '0;
            r_load   <= 1'b0;
            r_sop    <= 1'b0;
            r_valid  <= 1'b0;
            r_inrdy  <= 1'b0;
            r_outvld <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_nblk   <= w_nblk_nxt;
            r_blk    <= w_blk_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wd     <= w_wd_nxt;
            // Phase strobes follow the next state, so o_load drops with the last load pulse.
            r_load   <= (w_state_nxt == S_LOAD);
            r_sop    <= (w_state_nxt == S_PROC);
            r_valid  <= w_accept;
            r_outvld <= w_accept && (r_state == S_READ);
            r_inrdy  <= (w_state_nxt == S_LOAD) && !w_accept && (w_cnt_nxt <= {1'b0, w_len_nxt});
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
        end
    end

    assign o_inRdy     = r_inrdy;
    assign o_outVld    = r_outvld;
    assign o_load      = r_load;
    assign o_SoP       = r_sop;
    assign o_valid     = r_valid;
    assign o_imgLength = r_len;
    assign o_blockIdx  = r_blk;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_conv_block_scheduler.sv
// Scoreboard bench: jobs push their expected pulse stream, a monitor pops one entry per DUT event.
module tb_conv_block_scheduler;

    logic       i_CLK, i_reset, i_start, i_inVld, i_outRdy, i_EoP, i_changeBlock;
    logic [7:0] i_nBlocks;
    logic [9:0] i_imgLength;
    logic       o_inRdy, o_outVld, o_load, o_SoP, o_valid, o_busy, o_done, o_error;
    logic [9:0] o_imgLength;
    logic [7:0] o_blockIdx;

    conv_block_scheduler #(.NB_IMAGE(10), .NB_BLOCKS(8), .NB_TIMEOUT(12), .TIMEOUT(20)) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start), .i_nBlocks(i_nBlocks),
        .i_imgLength(i_imgLength), .i_inVld(i_inVld), .o_inRdy(o_inRdy), .i_outRdy(i_outRdy),
        .o_outVld(o_outVld), .o_load(o_load), .o_SoP(o_SoP), .o_valid(o_valid),
        .o_imgLength(o_imgLength), .i_EoP(i_EoP), .i_changeBlock(i_changeBlock),
        .o_blockIdx(o_blockIdx), .o_busy(o_busy), .o_done(o_done), .o_error(o_error));

    typedef struct packed {
        logic [1:0] kind;   // 0 load pulse, 1 read pulse, 2 done
        logic [7:0] blk;
        logic       ld;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0, n_fail = 0;
    int  cur_len = 0, mode = 0, req_nb = 0, req_len = 0;
    bit  cb_en = 1, poke_en = 0, start_req = 0;

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] all_outs();
        return {o_inRdy, o_outVld, o_load, o_SoP, o_valid, o_imgLength, o_blockIdx,
                o_busy, o_done, o_error};
    endfunction

    // Host, downstream and address-FSM stand-in; sole driver of the DUT data inputs.
    initial begin : drv
        int pulses, cb_cd, eop_cd, cyc;
        bit cb_pend, eop_arm;
        pulses = 0; cb_cd = 0; eop_cd = 0; cyc = 0; cb_pend = 0; eop_arm = 0;
        i_start = 0; i_nBlocks = '0; i_imgLength = '0; i_inVld = 0; i_outRdy = 0;
        i_EoP = 0; i_changeBlock = 0;
        forever begin
            @(negedge i_CLK);
            cyc++;
            i_changeBlock = 1'b0;
            i_EoP = 1'b0;
            case (mode)
                0: begin i_inVld = 1'b1; i_outRdy = 1'b1; end
                1: begin i_inVld = (cyc % 3 == 0); i_outRdy = (cyc % 3 == 1); end
                default: begin
                    i_inVld  = 1'($urandom_range(0, 1));
                    i_outRdy = 1'($urandom_range(0, 1));
                end
            endcase
            if (start_req) begin
                i_start = 1'b1; i_nBlocks = 8'(req_nb); i_imgLength = 10'(req_len);
                start_req = 0;
            end else if (poke_en && o_busy && $urandom_range(0, 7) == 0) begin
                i_start = 1'b1; i_nBlocks = 8'($urandom); i_imgLength = 10'($urandom);
            end else begin
                i_start = 1'b0;
            end
            if (!i_reset) begin
                pulses = 0; cb_pend = 0; eop_arm = 0;
            end else begin
                if (o_valid) pulses++;
                if (pulses == cur_len + 1) begin
                    pulses = 0; cb_pend = 1; cb_cd = $urandom_range(0, 3);
                end
                if (cb_pend) begin
                    if (cb_cd == 0) begin cb_pend = 0; i_changeBlock = cb_en; end
                    else cb_cd--;
                end else if (cb_en && (o_load || o_SoP) && $urandom_range(0, 5) == 0) begin
                    i_changeBlock = 1'b1;   // spurious, must be ignored outside wait states
                end
                if (!o_SoP) eop_arm = 0;
                else begin
                    if (!eop_arm) begin eop_arm = 1; eop_cd = $urandom_range(0, 4); end
                    if (eop_cd == 0) i_EoP = 1'b1;
                    else eop_cd--;
                end
            end
        end
    end

    initial begin : monitor
        ev_t e;
        logic [1:0] ak;
        bit pv;
        pv = 0;
        forever begin
            @(negedge i_CLK);
            if (!i_reset) pv = 0;
            else begin
                check(!(o_load && o_SoP), "load_sop_excl", int'(o_load & o_SoP), 0);
                check(!(o_valid && pv), "valid_two_cycles", int'(o_valid & pv), 0);
                check(!o_outVld || o_valid, "outvld_with_valid", int'(o_outVld), int'(o_valid));
                check(!o_inRdy || (o_load && !o_valid), "inrdy_rule", int'(o_inRdy), int'(o_load & !o_valid));
                if (o_valid || o_done) begin
                    ak = o_done ? 2'd2 : (o_outVld ? 2'd1 : 2'd0);
                    if (sb.size() == 0) check(1'b0, "unexpected_event", int'(ak), -1);
                    else begin
                        e = sb.pop_front();
                        check(ak == e.kind, "event_kind", int'(ak), int'(e.kind));
                        if (e.kind != 2'd2) begin
                            check(o_blockIdx == e.blk, "block_idx", int'(o_blockIdx), int'(e.blk));
                            check(o_load == e.ld, "load_level", int'(o_load), int'(e.ld));
                        end
                    end
                end
                pv = o_valid;
            end
        end
    end

    task automatic push_job(input int nb, input int len, input bit with_done);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i <= len; i++) sb.push_back('{kind: 2'd0, blk: 8'(b), ld: (i != len)});
            for (int i = 0; i <= len; i++) sb.push_back('{kind: 2'd1, blk: 8'(b), ld: 1'b0});
        end
        if (with_done) sb.push_back('{kind: 2'd2, blk: 8'd0, ld: 1'b0});
    endtask

    task automatic issue_start(input int nb, input int len);
        cur_len = len; req_nb = nb; req_len = len;
        start_req = 1;
        wait (start_req == 0);
        @(negedge i_CLK);
    endtask

    task automatic run_job(input int nb, input int len);
        int k;
        push_job(nb, len, 1'b1);
        issue_start(nb, len);
        check(o_busy == 1'b1, "busy_after_start", int'(o_busy), 1);
        check(o_error == 1'b0, "error_cleared", int'(o_error), 0);
        check(o_imgLength == 10'(len), "img_length", int'(o_imgLength), len);
        k = 0;
        while (!o_done && k < 20000) begin @(negedge i_CLK); k++; end
        check(o_done == 1'b1, "done_seen", int'(o_done), 1);
        if (nb == 0) check(k == 1, "zero_block_done_latency", k, 1);
        @(negedge i_CLK);
        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        check(!o_busy && !o_done, "idle_after_done", int'({o_busy, o_done}), 0);
    endtask

    initial begin : main
        int k;
        i_reset = 1'b0;
        repeat (3) @(negedge i_CLK);
        check(all_outs() == '0, "reset_state", int'(all_outs()), 0);
        i_reset = 1'b1;
        @(negedge i_CLK);

        run_job(1, 3);
        run_job(3, 3);
        mode = 1;
        run_job(1, 3);
        run_job(2, 5);
        mode = 0;
        run_job(0, 7);
        run_job(2, 0);
        mode = 2; poke_en = 1;
        for (int j = 0; j < 8; j++) run_job(int'($urandom_range(1, 3)), int'($urandom_range(0, 6)));
        poke_en = 0; mode = 0;
        run_job(1, 1023);

        // Watchdog: the FSM never acknowledges the loaded block.
        cb_en = 0;
        push_job(1, 3, 1'b0);
        for (int i = 0; i < 4; i++) sb.pop_back();    // keep only the load pulses
        issue_start(1, 3);
        k = 0;
        while (!o_load && k < 100) begin @(negedge i_CLK); k++; end
        while (o_load && k < 100) begin @(negedge i_CLK); k++; end
        k = 0;
        while (!o_error && k < 100) begin @(negedge i_CLK); k++; end
        check(o_error == 1'b1, "timeout_error", int'(o_error), 1);
        check(k == 20, "timeout_cycles", k, 20);
        check({o_busy, o_load, o_SoP, o_valid, o_done} == 5'b0, "timeout_outputs",
              int'({o_busy, o_load, o_SoP, o_valid, o_done}), 0);
        repeat (3) @(negedge i_CLK);
        check(o_error == 1'b1, "error_sticky", int'(o_error), 1);
        check(sb.size() == 0, "timeout_scoreboard", sb.size(), 0);
        cb_en = 1;
        run_job(1, 2);

        // Asynchronous reset while the FSM is processing.
        push_job(2, 4, 1'b1);
        issue_start(2, 4);
        k = 0;
        while (!o_SoP && k < 1000) begin @(negedge i_CLK); k++; end
        check(o_SoP == 1'b1, "reached_proc", int'(o_SoP), 1);
        #2 i_reset = 1'b0;
        #1 check(all_outs() == '0, "async_reset_outputs", int'(all_outs()), 0);
        sb.delete();
        repeat (2) @(negedge i_CLK);
        i_reset = 1'b1;
        @(negedge i_CLK);
        run_job(2, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
